// File: rtl/vec_cmd_issue_if.sv
// Scalar-to-vector command bundle: request side, three outbound
// queues (cmd, imm1, imm2) and the returning ack queue.
interface vec_cmd_issue_if #(
  parameter int CMD_SZ    = 20,
  parameter int IMM_SZ    = 64,
  parameter int STRIDE_SZ = 64,
  parameter int RESP_SZ   = 32
);
  logic                 req_val;
  logic                 req_rdy;
  logic [CMD_SZ-1:0]    req_cmd;
  logic [IMM_SZ-1:0]    req_imm1;
  logic [STRIDE_SZ-1:0] req_imm2;
  logic                 req_has_imm1;
  logic                 req_has_imm2;
  logic                 req_fence_cv;

  logic [CMD_SZ-1:0]    vec_cmdq_bits;
  logic                 vec_cmdq_val;
  logic                 vec_cmdq_rdy;
  logic [IMM_SZ-1:0]    vec_ximm1q_bits;
  logic                 vec_ximm1q_val;
  logic                 vec_ximm1q_rdy;
  logic [STRIDE_SZ-1:0] vec_ximm2q_bits;
  logic                 vec_ximm2q_val;
  logic                 vec_ximm2q_rdy;

  logic [RESP_SZ-1:0]   vec_ackq_bits;
  logic                 vec_ackq_val;
  logic                 vec_ackq_rdy;

  modport slave (
    input  req_val, req_cmd, req_imm1, req_imm2,
    input  req_has_imm1, req_has_imm2, req_fence_cv,
    output req_rdy,
    output vec_cmdq_bits, vec_cmdq_val,
    input  vec_cmdq_rdy,
    output vec_ximm1q_bits, vec_ximm1q_val,
    input  vec_ximm1q_rdy,
    output vec_ximm2q_bits, vec_ximm2q_val,
    input  vec_ximm2q_rdy,
    input  vec_ackq_bits, vec_ackq_val,
    output vec_ackq_rdy
  );

  modport master (
    output req_val, req_cmd, req_imm1, req_imm2,
    output req_has_imm1, req_has_imm2, req_fence_cv,
    input  req_rdy,
    input  vec_cmdq_bits, vec_cmdq_val,
    output vec_cmdq_rdy,
    input  vec_ximm1q_bits, vec_ximm1q_val,
    output vec_ximm1q_rdy,
    input  vec_ximm2q_bits, vec_ximm2q_val,
    output vec_ximm2q_rdy,
    output vec_ackq_bits, vec_ackq_val,
    input  vec_ackq_rdy
  );
endinterface

// File: rtl/vec_cmd_issue.sv
// Vector command issue: stages one request into cmd/imm1/imm2 queues
// and holds further issue while a fence_cv waits for its ack.
module vec_cmd_issue #(
  parameter int CMD_SZ    = 20,
  parameter int IMM_SZ    = 64,
  parameter int STRIDE_SZ = 64,
  parameter int RESP_SZ   = 32
) (
  input  logic           clk,
  input  logic           reset,
  vec_cmd_issue_if.slave io,
  output logic           fence_busy,
  output logic           ack_err
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_ACK
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CMD_SZ-1:0]    cmd_r;
  logic [IMM_SZ-1:0]    imm1_r;
  logic [STRIDE_SZ-1:0] imm2_r;
  logic pend_c;
  logic pend_1;
  logic pend_2;
  logic fence_r;
  logic err_r;

  logic fire_c;
  logic fire_1;
  logic fire_2;
  logic last_fire;
  logic rdy;
  logic accept;
  logic ack_bad;

  always_comb begin
    fire_c    = pend_c & io.vec_cmdq_rdy;
    fire_1    = pend_1 & io.vec_ximm1q_rdy;
    fire_2    = pend_2 & io.vec_ximm2q_rdy;
    last_fire = (~pend_c | io.vec_cmdq_rdy)
              & (~pend_1 | io.vec_ximm1q_rdy)
              & (~pend_2 | io.vec_ximm2q_rdy);
    rdy       = 1'b0;
    state_nxt = state;
    unique case (state)
      IDLE:     rdy = 1'b1;
      SEND:     rdy = last_fire & ~fence_r;
      WAIT_ACK: rdy = 1'b0;
      default:  rdy = 1'b0;
    endcase
    rdy    = rdy & ~reset;
    accept = io.req_val & rdy;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = SEND;
      end
      SEND: begin
        if (accept)
          state_nxt = SEND;
        else if (last_fire)
          state_nxt = fence_r ? WAIT_ACK : IDLE;
      end
      WAIT_ACK: begin
        if (io.vec_ackq_val) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Any ack outside WAIT_ACK, or a non-1 ack word, is a protocol error.
    ack_bad = io.vec_ackq_val
            & ((state != WAIT_ACK)
            | (io.vec_ackq_bits != RESP_SZ'(1)));
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_c  <= 1'b0;
      pend_1  <= 1'b0;
      pend_2  <= 1'b0;
      fence_r <= 1'b0;
      err_r   <= 1'b0;
      cmd_r   <= '0;
      imm1_r  <= '0;
      imm2_r  <= '0;
    end else begin
      err_r <= err_r | ack_bad;
      if (accept) begin
        pend_c  <= 1'b1;
        pend_1  <= io.req_has_imm1;
        pend_2  <= io.req_has_imm2;
        fence_r <= io.req_fence_cv;
        cmd_r   <= io.req_cmd;
        imm1_r  <= io.req_imm1;
        imm2_r  <= io.req_imm2;
      end else begin
        if (fire_c) pend_c <= 1'b0;
        if (fire_1) pend_1 <= 1'b0;
        if (fire_2) pend_2 <= 1'b0;
      end
    end
  end

  assign io.req_rdy         = rdy;
  assign io.vec_cmdq_val    = pend_c & ~reset;
  assign io.vec_ximm1q_val  = pend_1 & ~reset;
  assign io.vec_ximm2q_val  = pend_2 & ~reset;
  assign io.vec_cmdq_bits   = reset ? '0 : cmd_r;
  assign io.vec_ximm1q_bits = reset ? '0 : imm1_r;
  assign io.vec_ximm2q_bits = reset ? '0 : imm2_r;
  assign io.vec_ackq_rdy    = ~reset;
  assign fence_busy = ~reset & (state == WAIT_ACK);
  assign ack_err    = ~reset & err_r;

endmodule
